// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter and access sequencer for the single-port data memory.
// Define DM_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module dm_arbiter #(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] Ad,
  output logic [DW-1:0] WrData,
  output logic          MemWr,
  input  logic [DW-1:0] DM
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic lat_we, lat_id, arb, any_req, win;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  // a read in ACCESS must be followed by RESP, so it is the only state that skips arbitration
  assign arb = state != ACCESS || lat_we;
  assign any_req = r0_req | r1_req;
`ifdef DM_ARB_RR_EN
  logic last;
  assign win = (r0_req & r1_req) ? ~last : r1_req;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) last <= 1'b1;
    else if (arb && any_req) last <= win;
`else
  assign win = ~r0_req & r1_req;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      lat_we <= 1'b0;
      lat_id <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (arb && any_req) begin
        lat_we <= win ? r1_we : r0_we;
        lat_id <= win;
        lat_addr <= win ? r1_addr : r0_addr;
        lat_wdata <= win ? r1_wdata : r0_wdata;
      end
    end
  always_comb begin
    state_nxt = arb ? (any_req ? ACCESS : IDLE) : RESP;
    Ad = '0;
    WrData = '0;
    MemWr = 1'b0;
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    r0_rvalid = 1'b0;
    r1_rvalid = 1'b0;
    r0_rdata = '0;
    r1_rdata = '0;
    if (state == ACCESS) begin
      Ad = lat_addr;
      WrData = lat_we ? lat_wdata : '0;
      MemWr = lat_we;
      r0_gnt = ~lat_id;
      r1_gnt = lat_id;
    end
    if (state == RESP) begin
      Ad = lat_addr;
      r0_rvalid = ~lat_id;
      r1_rvalid = lat_id;
      r0_rdata = lat_id ? '0 : DM;
      r1_rdata = lat_id ? DM : '0;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios plus a randomized run against a transaction-level model
// of dm_arbiter with a behavioural registered-read memory.
module tb_dm_arbiter;
  localparam int AW = 30, DW = 32;
`ifdef DM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic Clk = 1'b0, Reset = 1'b1, mem_clr = 1'b1;
  logic r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0, Ad;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0, r0_rdata, r1_rdata, WrData, DM;
  logic r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, MemWr;
  logic [DW-1:0] mem [0:255];
  int checks = 0, errors = 0;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .Ad(Ad), .WrData(WrData), .MemWr(MemWr), .DM(DM)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (MemWr) mem[Ad[7:0]] <= WrData;
    DM <= mem[Ad[7:0]];
  end

  task automatic test_reset;
    r0_req = 1'b1; r1_req = 1'b1; r0_addr = 30'd1; r1_addr = 30'd2;
    repeat (2) begin
      @(negedge Clk);
      checks++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, MemWr} !== 5'b0 || Ad !== '0 || WrData !== '0 || r0_rdata !== '0 || r1_rdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b MemWr=%b Ad=%0h WrData=%0h, required all 0", r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, MemWr, Ad, WrData);
      end
    end
    mem_clr = 1'b0; Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL first_gnt: gnt0,1=%b%b, required 10", r0_gnt, r1_gnt); end
    r0_req = 1'b0;
    @(negedge Clk);
    checks++;
    if ({r0_rvalid, r1_gnt} !== 2'b10 || r0_rdata !== '0) begin errors++; $display("FAIL reset_first_resp: rvalid0=%b gnt1=%b rdata0=%h, required 1 0 0", r0_rvalid, r1_gnt, r0_rdata); end
    @(negedge Clk);
    checks++;
    if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL reset_loser_gnt: gnt0,1=%b%b, required 01", r0_gnt, r1_gnt); end
    r1_req = 1'b0;
    @(negedge Clk);
    checks++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== '0) begin errors++; $display("FAIL reset_loser_resp: rvalid1=%b rdata1=%h, required 1 0", r1_rvalid, r1_rdata); end
    @(negedge Clk);
    checks++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, MemWr} !== 5'b0) begin errors++; $display("FAIL reset_idle: gnt=%b%b rvalid=%b%b MemWr=%b, required 0", r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, MemWr); end
  endtask

  task automatic test_write_read;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 30'd5; r0_wdata = 32'hDEADBEEF;
    @(negedge Clk);
    checks++;
    if (r0_gnt !== 1'b1 || MemWr !== 1'b1 || Ad !== 30'd5 || WrData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_gnt: gnt0=%b MemWr=%b Ad=%0h WrData=%h, required 1 1 5 deadbeef", r0_gnt, MemWr, Ad, WrData);
    end
    r0_req = 1'b0;
    @(negedge Clk);
    checks++;
    if (r0_gnt !== 1'b0 || MemWr !== 1'b0 || Ad !== '0) begin errors++; $display("FAIL wr_one_cycle: gnt0=%b MemWr=%b Ad=%0h, required 0 0 0", r0_gnt, MemWr, Ad); end
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 30'd5;
    @(negedge Clk);
    checks++;
    if (r1_gnt !== 1'b1 || MemWr !== 1'b0 || Ad !== 30'd5 || WrData !== '0) begin errors++; $display("FAIL rd_gnt: gnt1=%b MemWr=%b Ad=%0h WrData=%h, required 1 0 5 0", r1_gnt, MemWr, Ad, WrData); end
    r1_req = 1'b0;
    @(negedge Clk);
    checks++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hDEADBEEF || r0_rdata !== '0 || r1_gnt !== 1'b0) begin
      errors++; $display("FAIL rd_resp: rvalid1=%b rdata1=%h rdata0=%h gnt1=%b, required 1 deadbeef 0 0", r1_rvalid, r1_rdata, r0_rdata, r1_gnt);
    end
    @(negedge Clk);
    checks++;
    if (r1_rvalid !== 1'b0 || r1_rdata !== '0) begin errors++; $display("FAIL rd_resp_end: rvalid1=%b rdata1=%h, required 0 0", r1_rvalid, r1_rdata); end
  endtask

  task automatic test_write_stream;
    r1_req = 1'b1; r1_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r1_addr = AW'(k); r1_wdata = DW'(32'h10 + k);
      @(negedge Clk);
      checks++;
      if (r1_gnt !== 1'b1 || MemWr !== 1'b1 || Ad !== AW'(k) || WrData !== DW'(32'h10 + k)) begin
        errors++; $display("FAIL ws_gnt[%0d]: gnt1=%b MemWr=%b Ad=%0h WrData=%h, required 1 1 %0h %h", k, r1_gnt, MemWr, Ad, WrData, k, 32'h10 + k);
      end
    end
    r1_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r1_req = 1'b1; r1_addr = AW'(k);
      @(negedge Clk);
      checks++;
      if (r1_gnt !== 1'b1 || MemWr !== 1'b0) begin errors++; $display("FAIL ws_rd_gnt[%0d]: gnt1=%b MemWr=%b, required 1 0", k, r1_gnt, MemWr); end
      r1_req = 1'b0;
      @(negedge Clk);
      checks++;
      if (r1_rvalid !== 1'b1 || r1_rdata !== DW'(32'h10 + k)) begin errors++; $display("FAIL ws_readback[%0d]: rvalid1=%b rdata1=%h, required 1 %h", k, r1_rvalid, r1_rdata, 32'h10 + k); end
    end
  endtask

  task automatic test_contention;
    int n = 0, k = 0;
    logic pv = 1'b0, pid = 1'b0, e1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 30'd5;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 30'd1;
    while (n < 8 && k < 40) begin
      @(negedge Clk);
      k++;
      checks++;
      if ({r0_rvalid, r1_rvalid} !== (pv ? {~pid, pid} : 2'b00) || (pv && (pid ? r1_rdata : r0_rdata) !== (pid ? 32'h11 : 32'hDEADBEEF))) begin
        errors++; $display("FAIL cont_rvalid: rvalid=%b%b rdata0=%h rdata1=%h, required grantee=%0d valid=%b", r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, pid, pv);
      end
      pv = 1'b0;
      if (r0_gnt | r1_gnt) begin
        e1 = RR && (n % 2 == 1);
        checks++;
        if (r1_gnt !== e1 || r0_gnt !== ~e1) begin errors++; $display("FAIL cont_gnt[%0d]: gnt0,1=%b%b, required %b%b", n, r0_gnt, r1_gnt, ~e1, e1); end
        pv = 1'b1; pid = r1_gnt; n++;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    checks++;
    if (n != 8 || k != 15) begin errors++; $display("FAIL cont_throughput: %0d grants in %0d cycles, required 8 in 15", n, k); end
    @(negedge Clk);
    checks++;
    if ({r0_rvalid, r1_rvalid} !== {~pid, pid} || (pid ? r1_rdata : r0_rdata) !== (pid ? 32'h11 : 32'hDEADBEEF)) begin
      errors++; $display("FAIL cont_last_rvalid: rvalid=%b%b, required grantee %0d", r0_rvalid, r1_rvalid, pid);
    end
  endtask

  task automatic test_interleave;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 30'd2;
    @(negedge Clk);
    checks++;
    if (r0_gnt !== 1'b1) begin errors++; $display("FAIL il_rd_gnt: gnt0=%b, required 1", r0_gnt); end
    r0_req = 1'b0; r1_req = 1'b1; r1_we = 1'b1; r1_addr = 30'd2; r1_wdata = 32'h55;
    @(negedge Clk);
    checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h12 || r1_gnt !== 1'b0 || MemWr !== 1'b0) begin
      errors++; $display("FAIL il_resp: rvalid0=%b rdata0=%h gnt1=%b MemWr=%b, required 1 12 0 0", r0_rvalid, r0_rdata, r1_gnt, MemWr);
    end
    @(negedge Clk);
    checks++;
    if (r1_gnt !== 1'b1 || MemWr !== 1'b1 || Ad !== 30'd2 || WrData !== 32'h55) begin
      errors++; $display("FAIL il_wr_gnt: gnt1=%b MemWr=%b Ad=%0h WrData=%h, required 1 1 2 55", r1_gnt, MemWr, Ad, WrData);
    end
    r1_req = 1'b0; r0_req = 1'b1;
    @(negedge Clk);
    checks++;
    if (r0_gnt !== 1'b1) begin errors++; $display("FAIL il_rd2_gnt: gnt0=%b, required 1", r0_gnt); end
    r0_req = 1'b0;
    @(negedge Clk);
    checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h55) begin errors++; $display("FAIL il_new_data: rvalid0=%b rdata0=%h, required 1 55", r0_rvalid, r0_rdata); end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_access;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 30'd7; r0_wdata = 32'h77;
    @(negedge Clk);
    checks++;
    if (r0_gnt !== 1'b1 || MemWr !== 1'b1) begin errors++; $display("FAIL rma_setup: gnt0=%b MemWr=%b, required 1 1", r0_gnt, MemWr); end
    Reset = 1'b1; r0_req = 1'b0;
    #1;
    checks++;
    if (r0_gnt !== 1'b0 || MemWr !== 1'b0) begin errors++; $display("FAIL rma_drop: gnt0=%b MemWr=%b, required 0 0", r0_gnt, MemWr); end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      checks++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, MemWr} !== 5'b0) begin
        errors++; $display("FAIL rma_quiet: gnt=%b%b rvalid=%b%b MemWr=%b, required 0", r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, MemWr);
      end
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] shadow [0:15];
    logic pend [2], outst [2], q_we [2];
    logic [3:0] q_ad [2];
    logic [DW-1:0] q_wd [2];
    logic last = 1'b1, prd = 1'b0, prd_id = 1'b0, any, w, emw;
    logic [3:0] rd_ad = '0;
    logic [DW-1:0] rd_exp = '0, ewd, er0, er1;
    logic [AW-1:0] ead;
    logic [1:0] eg, ev;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; outst[i] = 1'b0; q_we[i] = 1'b0; q_ad[i] = '0; q_wd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && !outst[i] && $urandom_range(0, 99) < 55) begin
          pend[i] = 1'b1;
          q_we[i] = 1'($urandom_range(0, 1));
          q_ad[i] = 4'($urandom_range(0, 15));
          q_wd[i] = $urandom;
        end
      r0_req = pend[0]; r0_we = q_we[0]; r0_addr = AW'(32 + q_ad[0]); r0_wdata = q_wd[0];
      r1_req = pend[1]; r1_we = q_we[1]; r1_addr = AW'(32 + q_ad[1]); r1_wdata = q_wd[1];
      @(negedge Clk);
      any = pend[0] | pend[1];
      w = (pend[0] & pend[1]) ? (RR ? ~last : 1'b0) : pend[1];
      eg = (!prd && any) ? {~w, w} : 2'b00;
      ev = prd ? {~prd_id, prd_id} : 2'b00;
      ead = eg != 2'b00 ? AW'(32 + q_ad[w]) : prd ? AW'(32 + rd_ad) : '0;
      emw = eg != 2'b00 && q_we[w];
      ewd = emw ? q_wd[w] : '0;
      er0 = ev == 2'b10 ? rd_exp : '0;
      er1 = ev == 2'b01 ? rd_exp : '0;
      checks++;
      if ({r0_gnt, r1_gnt} !== eg) begin errors++; $display("FAIL rand_gnt[%0d]: gnt0,1=%b%b, required %b", c, r0_gnt, r1_gnt, eg); end
      checks++;
      if ({r0_rvalid, r1_rvalid} !== ev) begin errors++; $display("FAIL rand_rvalid[%0d]: rvalid0,1=%b%b, required %b", c, r0_rvalid, r1_rvalid, ev); end
      checks++;
      if (Ad !== ead || MemWr !== emw || (!prd && WrData !== ewd) || r0_rdata !== er0 || r1_rdata !== er1) begin
        errors++;
        $display("FAIL rand_pins[%0d]: Ad=%0h MemWr=%b WrData=%h rdata0=%h rdata1=%h, required %0h %b %h %h %h", c, Ad, MemWr, WrData, r0_rdata, r1_rdata, ead, emw, ewd, er0, er1);
      end
      if (ev != 2'b00) outst[ev[0]] = 1'b0;
      prd = 1'b0;
      if (eg != 2'b00) begin
        last = w;
        pend[w] = 1'b0;
        if (q_we[w]) shadow[q_ad[w]] = q_wd[w];
        else begin
          prd = 1'b1; prd_id = w; rd_ad = q_ad[w]; rd_exp = shadow[q_ad[w]]; outst[w] = 1'b1;
        end
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_write_stream;
    test_contention;
    test_interleave;
    test_reset_mid_access;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer for the single-port data memory (`Datamemory`). It sits between the CPU load/store unit (requester 0) and the debug/loader port (requester 1) on one side, and the memory's `Ad`/`WrData`/`MemWr`/`DM` pins on the other. It grants one word access at a time and drives the memory pins from registered copies of the winning request. It returns read data with the memory's one-cycle registered-read latency accounted for.

## Interface
Parameters:
- `AW`, 30: word-address width; the address represents byte address bits [31:2].
- `DW`, 32: data width.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `rN_req`  in  1  (N = 0, 1) request; level-sampled on each rising edge.
- `rN_we`  in  1  1 = write, 0 = read; qualified by `rN_req`.
- `rN_addr`  in  AW  word address.
- `rN_wdata`  in  DW  write data.
- `rN_gnt`  out  1  one-cycle pulse: the request was accepted and is on the memory pins this cycle.
- `rN_rvalid`  out  1  one-cycle pulse: `rN_rdata` is valid.
- `rN_rdata`  out  DW  read data; equals `DM` while `rN_rvalid` = 1, otherwise 0.
- `Ad`  out  AW  memory word address.
- `WrData`  out  DW  memory write data.
- `MemWr`  out  1  memory write enable.
- `DM`  in  DW  memory read data, registered inside the memory; valid the cycle after `Ad` is presented with `MemWr` = 0.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: pins driven from the latched request; the memory writes, or captures read data, at the closing edge.
  - RESP: `DM` holds the read result.
- Arbitration happens at every edge whose next state is not RESP:
  - in IDLE;
  - in ACCESS when the latched op is a write;
  - in RESP.
- When arbitration finds a request, the winner's `we`/`addr`/`wdata` and ID are latched, and the next state is ACCESS. With no request, the next state is IDLE.
- ACCESS closing an op:
  - write: arbitrate again as above.
  - read: next state RESP.
- Outputs by state:
  - ACCESS: `Ad` = latched address. `WrData` = latched data for a write, 0 for a read. `MemWr` = latched `we`. `gnt` of the latched ID = 1.
  - RESP: `Ad` = latched address, `MemWr` = 0, `rvalid` of the latched ID = 1, its `rdata` = `DM`.
  - IDLE: `Ad`, `WrData` and `MemWr` all 0.
- Handshake rules:
  - A requester holds `req` and its qualifiers stable until it sees `gnt`.
  - A `req` still high in the `gnt` cycle is a new, independent request.
  - A requester has at most one outstanding read. It may issue its next request in the `rvalid` cycle.
- Tie-break for simultaneous requests: see Configuration.
- The losing request waits with `req` held. It is never dropped.

## Timing
- Reset (asynchronous) forces:
  - state to IDLE;
  - all outputs to 0, including immediate deassertion of `MemWr`;
  - the last-winner pointer to 1, so requester 0 wins the first tie.
- An access in flight at reset is abandoned. No `gnt` or `rvalid` is produced for it after reset releases.
- Write: `req` sampled at edge E0 → `gnt` and `MemWr` high in cycle E0..E1 → memory updated at E1.
- Read: `req` sampled at edge E0 → `gnt` in E0..E1 → `rvalid` and `rdata` in E1..E2. Read latency is 2 cycles from the sampling edge.
- Throughput:
  - back-to-back writes: 1 per cycle;
  - reads: 1 per 2 cycles;
  - a read followed by any op: the next ACCESS starts right after RESP.
- `gnt` and `rvalid` are never both high for the same requester in the same cycle. At most one `gnt` and one `rvalid` are high in any cycle.

## Configuration
- `DM_ARB_RR_EN`:
  - Defined: round-robin. On a tie, the requester that did not win the previous grant wins. The pointer updates on every grant.
  - Undefined: fixed priority. Requester 0 always wins a tie. The pointer logic is not compiled in, and requester 1 may starve.

## Test plan
- Reset: assert `Reset` for 2 cycles with both `req` high → all outputs 0 during reset. After release, first `gnt` = `r0_gnt`.
- Write then read: r0 writes addr 5, data 0xDEADBEEF → `r0_gnt` = 1, `MemWr` = 1, `Ad` = 5 for exactly one cycle. Then r1 reads addr 5 → `r1_rvalid` = 1 two cycles after sampling, `r1_rdata` = 0xDEADBEEF.
- Contention: both requesters hold read `req` continuously for 8 grants → with `DM_ARB_RR_EN`, grants alternate 0,1,0,1… and each `rvalid` matches its grantee. Without it, all 8 grants go to r0.
- Write streaming: r1 holds write `req` for 4 cycles with addrs 0..3 and data 0x10..0x13 → `r1_gnt` high for 4 consecutive cycles, and a later readback returns 0x10..0x13.
- Reset mid-access: assert `Reset` in the ACCESS cycle of an r0 write → `MemWr` and `r0_gnt` fall within the same cycle. After release, no `gnt` or `rvalid` occurs for that request.
- Read/write interleave: r0 reads addr 2 while r1's write to addr 2 (data 0x55) waits → r1 is granted in the RESP cycle's following cycle, and r0 receives the old data.
